// File: rtl/pspin_egress_dma_if.sv
// Bundle of descriptor, status, AXI4 read/write and AXI Stream signals around pspin_egress_dma.
// master is the DMA view, slave is the view of the environment driving it.
interface pspin_egress_dma_if #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 8
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;

    logic [AXI_ADDR_WIDTH-1:0] s_axis_read_desc_addr;
    logic [LEN_WIDTH-1:0]      s_axis_read_desc_len;
    logic [TAG_WIDTH-1:0]      s_axis_read_desc_tag;
    logic                      s_axis_read_desc_valid;
    logic                      s_axis_read_desc_ready;

    logic [TAG_WIDTH-1:0]      m_axis_read_desc_status_tag;
    logic [3:0]                m_axis_read_desc_status_error;
    logic                      m_axis_read_desc_status_valid;

    logic [AXI_ID_WIDTH-1:0]   m_axi_pspin_arid;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_pspin_araddr;
    logic [7:0]                m_axi_pspin_arlen;
    logic [2:0]                m_axi_pspin_arsize;
    logic [1:0]                m_axi_pspin_arburst;
    logic                      m_axi_pspin_arlock;
    logic [3:0]                m_axi_pspin_arcache;
    logic [2:0]                m_axi_pspin_arprot;
    logic                      m_axi_pspin_arvalid;
    logic                      m_axi_pspin_arready;

    logic [AXI_ID_WIDTH-1:0]   m_axi_pspin_rid;
    logic [AXI_DATA_WIDTH-1:0] m_axi_pspin_rdata;
    logic [1:0]                m_axi_pspin_rresp;
    logic                      m_axi_pspin_rlast;
    logic                      m_axi_pspin_rvalid;
    logic                      m_axi_pspin_rready;

    logic [AXI_ID_WIDTH-1:0]   m_axi_pspin_awid;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_pspin_awaddr;
    logic [7:0]                m_axi_pspin_awlen;
    logic [2:0]                m_axi_pspin_awsize;
    logic [1:0]                m_axi_pspin_awburst;
    logic                      m_axi_pspin_awlock;
    logic [3:0]                m_axi_pspin_awcache;
    logic [2:0]                m_axi_pspin_awprot;
    logic                      m_axi_pspin_awvalid;
    logic [AXI_DATA_WIDTH-1:0] m_axi_pspin_wdata;
    logic [BYTES-1:0]          m_axi_pspin_wstrb;
    logic                      m_axi_pspin_wlast;
    logic                      m_axi_pspin_wvalid;
    logic                      m_axi_pspin_bready;

    logic [AXI_DATA_WIDTH-1:0] m_axis_tx_tdata;
    logic [BYTES-1:0]          m_axis_tx_tkeep;
    logic                      m_axis_tx_tvalid;
    logic                      m_axis_tx_tlast;
    logic                      m_axis_tx_tuser;
    logic                      m_axis_tx_tready;

    modport master (
        input  s_axis_read_desc_addr, s_axis_read_desc_len, s_axis_read_desc_tag,
        input  s_axis_read_desc_valid,
        output s_axis_read_desc_ready,
        output m_axis_read_desc_status_tag, m_axis_read_desc_status_error,
        output m_axis_read_desc_status_valid,
        output m_axi_pspin_arid, m_axi_pspin_araddr, m_axi_pspin_arlen, m_axi_pspin_arsize,
        output m_axi_pspin_arburst, m_axi_pspin_arlock, m_axi_pspin_arcache, m_axi_pspin_arprot,
        output m_axi_pspin_arvalid,
        input  m_axi_pspin_arready,
        input  m_axi_pspin_rid, m_axi_pspin_rdata, m_axi_pspin_rresp, m_axi_pspin_rlast,
        input  m_axi_pspin_rvalid,
        output m_axi_pspin_rready,
        output m_axi_pspin_awid, m_axi_pspin_awaddr, m_axi_pspin_awlen, m_axi_pspin_awsize,
        output m_axi_pspin_awburst, m_axi_pspin_awlock, m_axi_pspin_awcache, m_axi_pspin_awprot,
        output m_axi_pspin_awvalid, m_axi_pspin_wdata, m_axi_pspin_wstrb, m_axi_pspin_wlast,
        output m_axi_pspin_wvalid, m_axi_pspin_bready,
        output m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tvalid, m_axis_tx_tlast,
        output m_axis_tx_tuser,
        input  m_axis_tx_tready
    );

    modport slave (
        output s_axis_read_desc_addr, s_axis_read_desc_len, s_axis_read_desc_tag,
        output s_axis_read_desc_valid,
        input  s_axis_read_desc_ready,
        input  m_axis_read_desc_status_tag, m_axis_read_desc_status_error,
        input  m_axis_read_desc_status_valid,
        input  m_axi_pspin_arid, m_axi_pspin_araddr, m_axi_pspin_arlen, m_axi_pspin_arsize,
        input  m_axi_pspin_arburst, m_axi_pspin_arlock, m_axi_pspin_arcache, m_axi_pspin_arprot,
        input  m_axi_pspin_arvalid,
        output m_axi_pspin_arready,
        output m_axi_pspin_rid, m_axi_pspin_rdata, m_axi_pspin_rresp, m_axi_pspin_rlast,
        output m_axi_pspin_rvalid,
        input  m_axi_pspin_rready,
        input  m_axi_pspin_awid, m_axi_pspin_awaddr, m_axi_pspin_awlen, m_axi_pspin_awsize,
        input  m_axi_pspin_awburst, m_axi_pspin_awlock, m_axi_pspin_awcache, m_axi_pspin_awprot,
        input  m_axi_pspin_awvalid, m_axi_pspin_wdata, m_axi_pspin_wstrb, m_axi_pspin_wlast,
        input  m_axi_pspin_wvalid, m_axi_pspin_bready,
        input  m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tvalid, m_axis_tx_tlast,
        input  m_axis_tx_tuser,
        output m_axis_tx_tready
    );
endinterface

// File: rtl/pspin_egress_dma.sv
// Egress DMA: one read descriptor at a time -> AXI4 INCR read bursts -> one AXI Stream frame.
// Optional statistics counters are built when PSPIN_EGRESS_DMA_STATS_EN is defined.
module pspin_egress_dma #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int LEN_WIDTH      = 20,
    parameter int TAG_WIDTH      = 8,
    parameter int MAX_BURST_LEN  = 16,
    parameter int MAX_LEN        = 1500
) (
    input  logic        clk,
    input  logic        rst,
    pspin_egress_dma_if.master bus,
    output logic [31:0] stat_frames,
    output logic [31:0] stat_bytes,
    output logic [31:0] stat_errors
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);

    localparam logic [3:0] ERR_OK   = 4'd0;
    localparam logic [3:0] ERR_LEN  = 4'd1;
    localparam logic [3:0] ERR_ADDR = 4'd2;
    localparam logic [3:0] ERR_AXI  = 4'd3;

    typedef enum logic [1:0] {IDLE, READ, STATUS} state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic [3:0]                err_q, err_d;
    logic [LEN_WIDTH-1:0]      ar_rem_q, ar_rem_d;
    logic [LEN_WIDTH-1:0]      r_rem_q, r_rem_d;
    logic                      rerr_q, rerr_d;
    logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [BYTES-1:0]          tkeep_q, tkeep_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;
    logic                      tuser_q, tuser_d;

    logic [12:0]          page_bytes;
    logic [LEN_WIDTH-1:0] page_beats;
    logic [LEN_WIDTH-1:0] burst_beats;
    logic [LEN_WIDTH-1:0] total_beats;
    logic [OFFS-1:0]      len_rem;
    logic [BYTES-1:0]     keep_last;
    logic                 arvalid;
    logic                 rready;
    logic                 ar_fire;
    logic                 r_fire;
    logic                 beat_err;

    // Beats left before the 4 KiB boundary; addr_q is always beat aligned in READ.
    assign page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign page_beats = LEN_WIDTH'(page_bytes >> OFFS);

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        burst_beats = ar_rem_q;
        if (burst_beats > LEN_WIDTH'(MAX_BURST_LEN)) burst_beats = LEN_WIDTH'(MAX_BURST_LEN);
        if (burst_beats > page_beats)                burst_beats = page_beats;
    end

    assign total_beats = (bus.s_axis_read_desc_len + LEN_WIDTH'(BYTES - 1)) >> OFFS;
    assign len_rem     = len_q[OFFS-1:0];
    assign keep_last   = (len_rem == '0) ? '1 : ~({BYTES{1'b1}} << len_rem);

    assign arvalid  = (state_q == READ) && (ar_rem_q != '0);
    assign rready   = (state_q == READ) && (!tvalid_q || bus.m_axis_tx_tready);
    assign ar_fire  = arvalid && bus.m_axi_pspin_arready;
    assign r_fire   = rready && bus.m_axi_pspin_rvalid;
    assign beat_err = rerr_q || (bus.m_axi_pspin_rresp != 2'b00);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        tag_d    = tag_q;
        err_d    = err_q;
        ar_rem_d = ar_rem_q;
        r_rem_d  = r_rem_q;
        rerr_d   = rerr_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q && !bus.m_axis_tx_tready;

        case (state_q)
            IDLE: begin
                if (bus.s_axis_read_desc_valid) begin
                    addr_d = bus.s_axis_read_desc_addr;
                    len_d  = bus.s_axis_read_desc_len;
                    tag_d  = bus.s_axis_read_desc_tag;
                    rerr_d = 1'b0;
                    if (bus.s_axis_read_desc_len == '0 ||
                        bus.s_axis_read_desc_len > LEN_WIDTH'(MAX_LEN)) begin
                        err_d   = ERR_LEN;
                        state_d = STATUS;
                    end else if (bus.s_axis_read_desc_addr[OFFS-1:0] != '0) begin
                        err_d   = ERR_ADDR;
                        state_d = STATUS;
                    end else begin
                        err_d    = ERR_OK;
                        ar_rem_d = total_beats;
                        r_rem_d  = total_beats;
                        state_d  = READ;
                    end
                end
            end
            READ: begin
                if (ar_fire) begin
                    addr_d   = addr_q + (AXI_ADDR_WIDTH'(burst_beats) << OFFS);
                    ar_rem_d = ar_rem_q - burst_beats;
                end
                if (r_fire) begin
                    tdata_d  = bus.m_axi_pspin_rdata;
                    tvalid_d = 1'b1;
                    rerr_d   = beat_err;
                    r_rem_d  = r_rem_q - 1'b1;
                    // Framing follows the descriptor beat count, never rlast.
                    if (r_rem_q == LEN_WIDTH'(1)) begin
                        tlast_d = 1'b1;
                        tkeep_d = keep_last;
                        tuser_d = beat_err;
                        err_d   = beat_err ? ERR_AXI : ERR_OK;
                        state_d = STATUS;
                    end else begin
                        tlast_d = 1'b0;
                        tkeep_d = '1;
                        tuser_d = 1'b0;
                    end
                end
            end
            STATUS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            tag_q    <= '0;
            err_q    <= '0;
            ar_rem_q <= '0;
            r_rem_q  <= '0;
            rerr_q   <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            ar_rem_q <= ar_rem_d;
            r_rem_q  <= r_rem_d;
            rerr_q   <= rerr_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign bus.s_axis_read_desc_ready        = (state_q == IDLE);
    assign bus.m_axis_read_desc_status_valid = (state_q == STATUS);
    assign bus.m_axis_read_desc_status_tag   = (state_q == STATUS) ? tag_q : '0;
    assign bus.m_axis_read_desc_status_error = (state_q == STATUS) ? err_q : '0;

    // AR fields are held at zero whenever no request is presented.
    assign bus.m_axi_pspin_arid    = AXI_ID_WIDTH'(0);
    assign bus.m_axi_pspin_araddr  = arvalid ? addr_q : '0;
    assign bus.m_axi_pspin_arlen   = arvalid ? 8'(burst_beats - 1'b1) : 8'd0;
    assign bus.m_axi_pspin_arsize  = arvalid ? 3'(OFFS) : 3'd0;
    assign bus.m_axi_pspin_arburst = arvalid ? 2'b01 : 2'b00;
    assign bus.m_axi_pspin_arlock  = 1'b0;
    assign bus.m_axi_pspin_arcache = arvalid ? 4'b0011 : 4'b0000;
    assign bus.m_axi_pspin_arprot  = 3'd0;
    assign bus.m_axi_pspin_arvalid = arvalid;
    assign bus.m_axi_pspin_rready  = rready;

    assign bus.m_axi_pspin_awid    = AXI_ID_WIDTH'(0);
    assign bus.m_axi_pspin_awaddr  = '0;
    assign bus.m_axi_pspin_awlen   = '0;
    assign bus.m_axi_pspin_awsize  = '0;
    assign bus.m_axi_pspin_awburst = '0;
    assign bus.m_axi_pspin_awlock  = 1'b0;
    assign bus.m_axi_pspin_awcache = '0;
    assign bus.m_axi_pspin_awprot  = '0;
    assign bus.m_axi_pspin_awvalid = 1'b0;
    assign bus.m_axi_pspin_wdata   = '0;
    assign bus.m_axi_pspin_wstrb   = '0;
    assign bus.m_axi_pspin_wlast   = 1'b0;
    assign bus.m_axi_pspin_wvalid  = 1'b0;
    assign bus.m_axi_pspin_bready  = 1'b0;

    assign bus.m_axis_tx_tdata  = tdata_q;
    assign bus.m_axis_tx_tkeep  = tkeep_q;
    assign bus.m_axis_tx_tvalid = tvalid_q;
    assign bus.m_axis_tx_tlast  = tlast_q;
    assign bus.m_axis_tx_tuser  = tuser_q;

    logic unused_ok;
    assign unused_ok = ^{bus.m_axi_pspin_rid, bus.m_axi_pspin_rlast, len_q};

`ifdef PSPIN_EGRESS_DMA_STATS_EN
    logic [31:0] frames_q, frames_d;
    logic [31:0] bytes_q, bytes_d;
    logic [31:0] errors_q, errors_d;

    always_comb begin
        frames_d = frames_q;
        bytes_d  = bytes_q;
        errors_d = errors_q;
        if (state_q == STATUS) begin
            if (err_q == ERR_OK) begin
                frames_d = frames_q + 32'd1;
                bytes_d  = bytes_q + 32'(len_q);
            end else begin
                errors_d = errors_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q <= '0;
            bytes_q  <= '0;
            errors_q <= '0;
        end else begin
            frames_q <= frames_d;
            bytes_q  <= bytes_d;
            errors_q <= errors_d;
        end
    end

    assign stat_frames = frames_q;
    assign stat_bytes  = bytes_q;
    assign stat_errors = errors_q;
`else
    assign stat_frames = '0;
    assign stat_bytes  = '0;
    assign stat_errors = '0;
`endif
endmodule

// File: tb/tb_pspin_egress_dma.sv
// Directed bench for pspin_egress_dma: AXI read slave model plus scoreboards for AR, AXIS beats and status.
module tb_pspin_egress_dma;
    localparam int DW    = 512;
    localparam int AW    = 32;
    localparam int LW    = 20;
    localparam int TW    = 8;
    localparam int BYTES = DW / 8;

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic [BYTES-1:0] keep; logic last; logic user; } beat_t;
    typedef struct { logic [TW-1:0] tag; logic [3:0] err; logic with_beats; } st_t;
    typedef struct { logic [31:0] addr; int beats; } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] stat_frames, stat_bytes, stat_errors;

    pspin_egress_dma_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(8),
                          .LEN_WIDTH(LW), .TAG_WIDTH(TW)) bus ();

    pspin_egress_dma #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(8), .LEN_WIDTH(LW),
        .TAG_WIDTH(TW), .MAX_BURST_LEN(16), .MAX_LEN(1500)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .stat_frames(stat_frames),
        .stat_bytes(stat_bytes),
        .stat_errors(stat_errors)
    );

    int tests = 0;
    int fails = 0;
    int ar_cycles = 0;
    logic [31:0] slverr_addr = 32'hFFFF_FFFF;

    ar_t   exp_ar[$];
    beat_t exp_beats[$];
    st_t   exp_st[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input logic [31:0] a);
        return {16{a ^ 32'hC0DE_0000}};
    endfunction

    // AXI read slave: queues accepted bursts and returns beats in order.
    initial begin : axi_slave
        burst_t      pend[$];
        int          beat_i;
        logic        ar_f, r_f;
        logic [31:0] ar_a, a;
        logic [7:0]  ar_l;
        beat_i = 0;
        bus.m_axi_pspin_rvalid = 1'b0;
        bus.m_axi_pspin_rdata  = '0;
        bus.m_axi_pspin_rresp  = 2'b00;
        bus.m_axi_pspin_rlast  = 1'b0;
        bus.m_axi_pspin_rid    = '0;
        forever begin
            @(negedge clk);
            ar_f = bus.m_axi_pspin_arvalid && bus.m_axi_pspin_arready;
            r_f  = bus.m_axi_pspin_rvalid && bus.m_axi_pspin_rready;
            ar_a = bus.m_axi_pspin_araddr;
            ar_l = bus.m_axi_pspin_arlen;
            @(posedge clk);
            #1;
            if (r_f && pend.size() > 0) begin
                beat_i++;
                if (beat_i == pend[0].beats) begin
                    void'(pend.pop_front());
                    beat_i = 0;
                end
            end
            if (ar_f) pend.push_back('{ar_a, int'(ar_l) + 1});
            if (pend.size() > 0) begin
                a = pend[0].addr + 32'(beat_i * BYTES);
                bus.m_axi_pspin_rvalid = 1'b1;
                bus.m_axi_pspin_rdata  = data_of(a);
                bus.m_axi_pspin_rresp  = (a == slverr_addr) ? 2'b10 : 2'b00;
                bus.m_axi_pspin_rlast  = (beat_i == pend[0].beats - 1);
            end else begin
                bus.m_axi_pspin_rvalid = 1'b0;
                bus.m_axi_pspin_rlast  = 1'b0;
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (bus.m_axi_pspin_arvalid) ar_cycles++;
        if (bus.m_axi_pspin_arvalid && bus.m_axi_pspin_arready) begin
            if (exp_ar.size() == 0) check("ar_extra", DW'(exp_ar.size()), DW'(1));
            else begin
                ar_t e;
                e = exp_ar.pop_front();
                check("araddr", DW'(bus.m_axi_pspin_araddr), DW'(e.addr));
                check("arlen", DW'(bus.m_axi_pspin_arlen), DW'(e.len));
                check("ar_attr", DW'({bus.m_axi_pspin_arsize, bus.m_axi_pspin_arburst,
                                      bus.m_axi_pspin_arcache, bus.m_axi_pspin_arlock,
                                      bus.m_axi_pspin_arprot}),
                      DW'({3'd6, 2'b01, 4'b0011, 1'b0, 3'b000}));
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (bus.m_axis_tx_tvalid && bus.m_axis_tx_tready) begin
            if (exp_beats.size() == 0) check("beat_extra", DW'(exp_beats.size()), DW'(1));
            else begin
                beat_t e;
                e = exp_beats.pop_front();
                check("tdata", bus.m_axis_tx_tdata, e.data);
                check("tkeep", DW'(bus.m_axis_tx_tkeep), DW'(e.keep));
                check("tlast_tuser", DW'({bus.m_axis_tx_tlast, bus.m_axis_tx_tuser}),
                      DW'({e.last, e.user}));
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        if (bus.m_axis_read_desc_status_valid) begin
            if (exp_st.size() == 0) check("status_extra", DW'(exp_st.size()), DW'(1));
            else begin
                st_t e;
                e = exp_st.pop_front();
                check("status_tag", DW'(bus.m_axis_read_desc_status_tag), DW'(e.tag));
                check("status_err", DW'(bus.m_axis_read_desc_status_error), DW'(e.err));
                check("status_ready", DW'(bus.s_axis_read_desc_ready), DW'(1'b0));
                if (e.with_beats)
                    check("status_with_tlast", DW'({bus.m_axis_tx_tvalid, bus.m_axis_tx_tlast}),
                          DW'(2'b11));
            end
        end
    end

    // Builds the expected AR bursts, beats and status for a descriptor, then hands it over.
    task automatic send_desc(input logic [31:0] addr, input logic [LW-1:0] len, input logic [TW-1:0] tag);
        logic [3:0]       e;
        int               beats, rem, b, pg, n;
        logic [31:0]      a, ba;
        logic             bad, last;
        logic [BYTES-1:0] keep;
        bad = 1'b0;
        if (len == '0 || len > LW'(1500)) e = 4'd1;
        else if (addr[5:0] != 6'd0)       e = 4'd2;
        else                              e = 4'd0;
        if (e == 4'd0) begin
            beats = (int'(len) + BYTES - 1) / BYTES;
            a = addr;
            rem = beats;
            while (rem > 0) begin
                b  = (rem > 16) ? 16 : rem;
                pg = (4096 - int'(a[11:0])) / BYTES;
                if (b > pg) b = pg;
                exp_ar.push_back('{a, 8'(b - 1)});
                a   = a + 32'(b * BYTES);
                rem = rem - b;
            end
            for (int i = 0; i < beats; i++) begin
                ba = addr + 32'(i * BYTES);
                if (ba == slverr_addr) bad = 1'b1;
                last = (i == beats - 1);
                if (last && (int'(len) % BYTES) != 0) keep = (64'h1 << (int'(len) % BYTES)) - 64'h1;
                else keep = '1;
                exp_beats.push_back('{data_of(ba), keep, last, last && bad});
            end
            if (bad) e = 4'd3;
        end
        exp_st.push_back('{tag, e, (e == 4'd0) || (e == 4'd3)});

        @(posedge clk);
        #1;
        bus.s_axis_read_desc_addr  = addr;
        bus.s_axis_read_desc_len   = len;
        bus.s_axis_read_desc_tag   = tag;
        bus.s_axis_read_desc_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_axis_read_desc_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("desc_ready", DW'(bus.s_axis_read_desc_ready), DW'(1'b1));
        @(posedge clk);
        #1;
        bus.s_axis_read_desc_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_ar.size() + exp_beats.size() + exp_st.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", DW'(exp_ar.size() + exp_beats.size() + exp_st.size()), DW'(0));
    endtask

    initial begin : stimulus
        int n, ar_before;
        bus.s_axis_read_desc_addr  = '0;
        bus.s_axis_read_desc_len   = '0;
        bus.s_axis_read_desc_tag   = '0;
        bus.s_axis_read_desc_valid = 1'b0;
        bus.m_axi_pspin_arready    = 1'b1;
        bus.m_axis_tx_tready       = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_ready", DW'(bus.s_axis_read_desc_ready), DW'(1'b1));
        check("rst_outputs", DW'({bus.m_axi_pspin_arvalid, bus.m_axi_pspin_rready,
                                  bus.m_axis_tx_tvalid, bus.m_axis_read_desc_status_valid,
                                  bus.m_axi_pspin_arsize, bus.m_axi_pspin_arcache}), DW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", DW'(bus.s_axis_read_desc_ready), DW'(1'b1));

        // Basic 2-beat frame; first arvalid the cycle after acceptance.
        send_desc(32'h0000_1000, 20'd128, 8'h5A);
        @(negedge clk);
        check("first_arvalid", DW'(bus.m_axi_pspin_arvalid), DW'(1'b1));
        wait_idle(500);
        @(negedge clk);
`ifdef PSPIN_EGRESS_DMA_STATS_EN
        check("stat_frames", DW'(stat_frames), DW'(1));
        check("stat_bytes", DW'(stat_bytes), DW'(128));
`else
        check("stat_off", DW'({stat_frames, stat_bytes, stat_errors}), DW'(0));
`endif

        // Partial last beat.
        send_desc(32'h0000_2000, 20'd100, 8'h01);
        wait_idle(500);

        // 4 KiB boundary split.
        send_desc(32'h0000_0FC0, 20'd256, 8'h02);
        wait_idle(500);

        // Length and alignment errors: no AR traffic at all.
        ar_before = ar_cycles;
        send_desc(32'h0000_1000, 20'd0, 8'h03);
        wait_idle(100);
        send_desc(32'h0000_1004, 20'd64, 8'h04);
        wait_idle(100);
        send_desc(32'h0000_1000, 20'd1501, 8'h05);
        wait_idle(100);
        check("err_no_ar", DW'(ar_cycles - ar_before), DW'(0));

        // Largest legal length: 24 beats over two bursts.
        send_desc(32'h0000_3000, 20'd1500, 8'h06);
        wait_idle(1000);

        // SLVERR on the first of three beats.
        slverr_addr = 32'h0000_4000;
        send_desc(32'h0000_4000, 20'd192, 8'h07);
        wait_idle(500);
        slverr_addr = 32'hFFFF_FFFF;

        // Backpressure: tready low for 5 cycles mid-frame.
        send_desc(32'h0000_5000, 20'd512, 8'h08);
        n = 0;
        @(negedge clk);
        while (!(bus.m_axis_tx_tvalid && bus.m_axi_pspin_rvalid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach", DW'(bus.m_axis_tx_tvalid && bus.m_axi_pspin_rvalid), DW'(1'b1));
        @(posedge clk);
        #1;
        bus.m_axis_tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rready_low", DW'(bus.m_axi_pspin_rready), DW'(1'b0));
            check("bp_tvalid_held", DW'(bus.m_axis_tx_tvalid), DW'(1'b1));
        end
        @(posedge clk);
        #1;
        bus.m_axis_tx_tready = 1'b1;
        wait_idle(1000);

        repeat (5) @(negedge clk);
        check("final_idle", DW'({bus.s_axis_read_desc_ready, bus.m_axis_tx_tvalid,
                                 bus.m_axi_pspin_arvalid}), DW'(3'b100));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
